alu_serial_rx: RTL
==================

// Module: alu_serial_rx
// PURPOSE
// - Serial input stage of the ALU: samples the 1-bit serial line, assembles 11-bit packets,
//   collects 8 data packets (B then A, MSB byte first) plus 1 command packet.
// - Checks framing, packet count, CRC4 and opcode; hands {A, B, op, error flags} to the ALU core
//   over a valid/ready handshake. Sits directly upstream of the ALU core.
// PARAMETERS
// - DATA_PKTS       8    data packets per frame (fixed protocol value, 4 for B + 4 for A)
// - TIMEOUT_CYCLES  64   idle cycles between packets before frame abort (ALU_RX_TIMEOUT_EN only)
// PORTS
// - clk        in   1   clock, sin sampled on rising edge, one bit per cycle
// - rst        in   1   asynchronous, active-high reset
// - sin        in   1   serial line, idle high
// - out_valid  out  1   result word valid for the core
// - out_ready  in   1   core accepts word when out_valid && out_ready
// - out_a      out  32  operand A
// - out_b      out  32  operand B
// - out_op     out  3   operation_t (valid only when out_err.op == 0)
// - out_err    out  3   error_flags_t {data, crc, op}
// - busy       out  1   high from first start bit until handshake completes
// BEHAVIOUR
// - Reset: state IDLE, out_valid=0, out_a=out_b=0, out_op=AND_OPERATION, out_err=0, busy=0, counters 0.
// - Packet (11 bits, MSB first): start=0, type (0 data / 1 cmd), payload[7:0], stop=1.
//   Cmd payload = {1'b0, op[2:0], crc[3:0]}.
// - FSM: IDLE -(sin==0)-> SHIFT (10 more bits) -> CHECK (1 cycle) -> IDLE | WAIT_GAP | HOLD.
//   - data pkt: byte shifted into {B,A} 64-bit reg; pkt_cnt++ (saturates at 15); go to WAIT_GAP.
//   - WAIT_GAP: behaves as IDLE but busy stays 1.
//   - cmd pkt: evaluate errors, latch outputs, go to HOLD.
//   - HOLD: out_valid=1; outputs stable; on out_ready -> IDLE, pkt_cnt=0, busy=0.
// - Latency: out_valid rises on the 2nd cycle after the cmd stop bit is sampled (CHECK, then HOLD).
// - Error rules, evaluated in CHECK:
//   - data: pkt_cnt != 8, or stop bit == 0 on any packet of the frame.
//   - crc: CRC4 (poly x^4+x+1, init 0) over {B, A, 1'b1, op} (68 bits) != received crc.
//   - op: op not in {AND, OR, ADD, SUB}.
//   - data error forces crc=op=0; otherwise crc and op are independent and may both be 1.
// - Bad stop bit on a data packet: sticky frame error; frame continues until the cmd packet.
// - 9th+ data packet before cmd: shift continues (oldest byte lost), data error at cmd.
// - HOLD: sin ignored (upstream must not send); start bits during HOLD are dropped.
// - Reset mid-frame or mid-HOLD: frame discarded, outputs return to reset values next edge.
// CONFIGURATION
// - ALU_RX_TIMEOUT_EN defined: gap counter in WAIT_GAP; gap > TIMEOUT_CYCLES aborts the frame
//   silently (pkt_cnt=0, reg cleared, busy=0, no out_valid).
// - ALU_RX_TIMEOUT_EN undefined: no counter; WAIT_GAP waits indefinitely; TIMEOUT_CYCLES unused.
// STRUCTURE
// - Shared package: operation_t, error_flags_t, packet_t, in_crc_t, packet field constants
//   (START/STOP bit, type values), DATA_PKTS, function crc4_calc().
// - One sub-module: alu_rx_shifter (11-bit shift register with bit counter and pkt_done strobe).
//   FSM, error logic and output registers live in alu_serial_rx.
// TESTING
// - ADD, A=1, B=2, correct CRC, out_ready=1 -> out_a=1, out_b=2, out_op=ADD, out_err=3'b000,
//   out_valid for exactly 1 cycle.
// - SUB, A=0, B=0xFFFF_FFFF, CRC bits inverted -> out_err=3'b010, out_a/out_b still latched.
// - Only 7 data packets then cmd -> out_err=3'b100 (crc and op bits forced 0).
// - Opcode 3'b111 with correct CRC -> out_err=3'b001.
// - AND frame, out_ready held 0 for 10 cycles -> out_valid and data stable 10 cycles;
//   rst pulse during 5th data packet -> no out_valid, busy=0.
// - ALU_RX_TIMEOUT_EN: gap of TIMEOUT_CYCLES+1 after 4th data packet -> abort, busy=0;
//   the next full valid frame is received correctly.

Source files
------------

// File: rtl/alu_serial_rx_pkg.sv
// Shared types, packet field constants and CRC helper for the ALU serial receive path.
package alu_serial_rx_pkg;

   typedef enum logic [2:0] {
      AND_OPERATION = 3'b000,
      OR_OPERATION  = 3'b001,
      ADD_OPERATION = 3'b100,
      SUB_OPERATION = 3'b101
   } operation_t;

   typedef struct packed {
      logic data;
      logic crc;
      logic op;
   } error_flags_t;

   // 11-bit packet in wire order, MSB first
   typedef struct packed {
      logic       start;
      logic       ptype;
      logic [7:0] payload;
      logic       stop;
   } packet_t;

   typedef struct packed {
      logic       zero;
      logic [2:0] op;
      logic [3:0] crc;
   } in_crc_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic TYPE_DATA = 1'b0;
   localparam logic TYPE_CMD  = 1'b1;
   localparam int   DATA_PKTS = 8;
   localparam int   PKT_BITS  = 11;

   // CRC4, poly x^4+x+1, init 0, message consumed MSB first
   function automatic logic [3:0] crc4_calc(input logic [67:0] msg);
      logic [3:0] c;
      logic       fb;
      c = 4'h0;
      for (int i = 67; i >= 0; i--) begin
         fb = c[3] ^ msg[i];
         c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
      end
      return c;
   endfunction

   function automatic logic op_is_valid(input logic [2:0] op);
      return (op == AND_OPERATION) || (op == OR_OPERATION) ||
             (op == ADD_OPERATION) || (op == SUB_OPERATION);
   endfunction

endpackage

// File: rtl/alu_rx_shifter.sv
// 11-bit serial-to-parallel packet shifter; pkt_done is high while the last (stop) bit is sampled.
// Starts on a low sin only while en is high; the packet stays in pkt until the next start.
module alu_rx_shifter
   import alu_serial_rx_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    sin,
   input  logic    en,
   output logic    pkt_done,
   output packet_t pkt
);

   logic        active;
   logic [3:0]  cnt;
   logic [10:0] sh;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active <= 1'b0;
         cnt    <= 4'd0;
         sh     <= 11'd0;
      end else if (active) begin
         sh <= {sh[9:0], sin};
         if (cnt == 4'(PKT_BITS - 1)) begin
            active <= 1'b0;
            cnt    <= 4'd0;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end else if (en && sin == START_BIT) begin
         active <= 1'b1;
         cnt    <= 4'd1;
         sh     <= {sh[9:0], sin};
      end
   end

   assign pkt_done = active && (cnt == 4'(PKT_BITS - 1));
   assign pkt      = packet_t'(sh);

endmodule

// File: rtl/alu_serial_rx.sv
// Serial receive front end of the ALU: frames 8 data + 1 cmd packet into {A, B, op, err}; out_valid 2 cycles after cmd stop bit.
// Result is held until out_ready; serial input is ignored meanwhile. ALU_RX_TIMEOUT_EN enables the inter-packet gap abort.
module alu_serial_rx
   import alu_serial_rx_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sin,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [2:0]  out_op,
   output logic [2:0]  out_err,
   output logic        busy
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SHIFT    = 3'd1;
   localparam logic [2:0] S_CHECK    = 3'd2;
   localparam logic [2:0] S_WAIT_GAP = 3'd3;
   localparam logic [2:0] S_HOLD     = 3'd4;

   logic [2:0]   state;
   logic [63:0]  data_reg;
   logic [3:0]   pkt_cnt;
   logic         frame_err;
   logic         listen;
   logic         pkt_done;
   packet_t      pkt;
   in_crc_t      cmd;
   logic         unused_rsvd;
   logic         framing_bad;
   logic         gap_expired;
   error_flags_t err_next;

   assign listen = (state == S_IDLE) || (state == S_WAIT_GAP);

   alu_rx_shifter u_shifter (
      .clk      (clk),
      .rst      (rst),
      .sin      (sin),
      .en       (listen),
      .pkt_done (pkt_done),
      .pkt      (pkt)
   );

   assign cmd         = in_crc_t'(pkt.payload);
   assign unused_rsvd = cmd.zero;
   assign framing_bad = (pkt.start != START_BIT) || (pkt.stop != STOP_BIT);

`ifdef ALU_RX_TIMEOUT_EN
   localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [GAP_W-1:0] gap_cnt;

   assign gap_expired = (state == S_WAIT_GAP) && sin && (gap_cnt == GAP_W'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         gap_cnt <= '0;
      else if (state == S_WAIT_GAP && sin)
         gap_cnt <= gap_cnt + 1'b1;
      else
         gap_cnt <= '0;
   end
`else
   assign gap_expired = 1'b0;
`endif

   // A framing/count problem makes the CRC and opcode meaningless, so they are not reported
   always_comb begin
      err_next      = '0;
      err_next.data = (pkt_cnt != 4'(DATA_PKTS)) || frame_err || framing_bad;
      if (!err_next.data) begin
         err_next.crc = crc4_calc({data_reg, 1'b1, cmd.op}) != cmd.crc;
         err_next.op  = !op_is_valid(cmd.op);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         data_reg  <= 64'd0;
         pkt_cnt   <= 4'd0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_a     <= 32'd0;
         out_b     <= 32'd0;
         out_op    <= AND_OPERATION;
         out_err   <= 3'b000;
      end else begin
         case (state)
            S_IDLE, S_WAIT_GAP: begin
               if (sin == START_BIT) begin
                  state <= S_SHIFT;
                  busy  <= 1'b1;
               end else if (gap_expired) begin
                  state     <= S_IDLE;
                  data_reg  <= 64'd0;
                  pkt_cnt   <= 4'd0;
                  frame_err <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (pkt_done)
                  state <= S_CHECK;
            end
            S_CHECK: begin
               if (pkt.ptype == TYPE_DATA) begin
                  data_reg <= {data_reg[55:0], pkt.payload};
                  if (pkt_cnt != 4'hF)
                     pkt_cnt <= pkt_cnt + 4'd1;
                  if (framing_bad)
                     frame_err <= 1'b1;
                  state <= S_WAIT_GAP;
               end else begin
                  out_valid <= 1'b1;
                  out_a     <= data_reg[31:0];
                  out_b     <= data_reg[63:32];
                  out_op    <= cmd.op;
                  out_err   <= err_next;
                  state     <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  data_reg  <= 64'd0;
                  pkt_cnt   <= 4'd0;
                  frame_err <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
